guard_frame_filter: RTL

//  Consumes the 1-bit predicate stream produced by the guard-predicate stage and applies it to an AXI-Stream event/frame stream.

---
 rtl/guard_frame_filter_if.sv | 15 +
 rtl/guard_frame_filter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/guard_frame_filter_if.sv
// AXI-Stream frame beat bundle (data, byte enables, last) used on both sides of guard_frame_filter.
// The master drives payload and valid; the slave drives ready.
interface guard_frame_filter_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/guard_frame_filter.sv
// Pops one guard predicate per frame: pass frames go through a registered 2-entry skid, drop frames are discarded.
// Define GUARD_DROP_CNT_EN to add saturating pass_frame_count / drop_frame_count outputs.
module guard_frame_filter #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_guard_tdata,
  input  logic                 s_guard_tvalid,
  output logic                 s_guard_tready,
  guard_frame_filter_if.slave  s_axis,
  guard_frame_filter_if.master m_axis
`ifdef GUARD_DROP_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] pass_frame_count,
  output logic [CNT_WIDTH-1:0] drop_frame_count
`endif
);

  localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t state, state_next;

  logic              guard_rdy;
  logic              in_rdy;
  logic              pred_pop;
  logic              push;
  logic              pop;
  logic              buf_rdy;
  logic [BEAT_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  // Readiness derives only from the registered fill level, never from m_axis.tready.
  assign buf_rdy = (count != 2'd2);
  assign pop     = m_axis.tvalid && m_axis.tready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (pred_pop && !s_axis.tlast) state_next = s_guard_tdata ? PASS : DROP;
      PASS, DROP: if (s_axis.tvalid && in_rdy && s_axis.tlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Predicate and first beat share one handshake so neither is ever consumed alone.
  always_comb begin
    guard_rdy = 1'b0;
    in_rdy    = 1'b0;
    pred_pop  = 1'b0;
    push      = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (s_guard_tvalid && s_axis.tvalid) begin
            pred_pop  = s_guard_tdata ? buf_rdy : 1'b1;
            push      = s_guard_tdata && buf_rdy;
            guard_rdy = pred_pop;
            in_rdy    = pred_pop;
          end
        end
        PASS: begin
          in_rdy = buf_rdy;
          push   = s_axis.tvalid && buf_rdy;
        end
        DROP: in_rdy = 1'b1;
        default: ;
      endcase
    end
  end

  assign s_guard_tready = guard_rdy;
  assign s_axis.tready  = in_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      count  <= count + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_axis.tdata, s_axis.tkeep, s_axis.tlast};
  end

  assign m_axis.tvalid = (count != 2'd0);
  assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast} = mem[rd_ptr];

`ifdef GUARD_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass_frame_count <= '0;
      drop_frame_count <= '0;
    end else if (pred_pop) begin
      if (s_guard_tdata) begin
        if (pass_frame_count != '1) pass_frame_count <= pass_frame_count + CNT_WIDTH'(1);
      end else begin
        if (drop_frame_count != '1) drop_frame_count <= drop_frame_count + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule
